// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared constants for the sprite ROM arbiter: requester IDs, sprite sheet
// layout and default bus widths.
package sprite_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 24;

  typedef enum logic [2:0] {
    REQ_PACMAN = 3'd0,
    REQ_GHOST  = 3'd1,
    REQ_ITEMS  = 3'd2,
    REQ_FONT   = 3'd3
  } req_id_e;

  // 26x26 pixel frames; sheets are packed back to back in the ROM
  localparam int SPRITE_FRAME_WORDS = 676;

  localparam logic [ADDR_W_DEF-1:0] BASE_PACMAN = 12'h000;
  localparam logic [ADDR_W_DEF-1:0] BASE_GHOST  = 12'h2A4;
  localparam logic [ADDR_W_DEF-1:0] BASE_ITEMS  = 12'h548;
  localparam logic [ADDR_W_DEF-1:0] BASE_FONT   = 12'h7EC;

  function automatic logic [ADDR_W_DEF-1:0] sheet_base(input req_id_e id);
    case (id)
      REQ_PACMAN: sheet_base = BASE_PACMAN;
      REQ_GHOST:  sheet_base = BASE_GHOST;
      REQ_ITEMS:  sheet_base = BASE_ITEMS;
      REQ_FONT:   sheet_base = BASE_FONT;
      default:    sheet_base = '0;
    endcase
  endfunction

  // Index width that stays legal for a single requester
  function automatic int idx_w(input int n);
    idx_w = (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Request / ROM / response bundle between the sprite address generators,
// the arbiter and the shared sprite ROM.
interface sprite_rom_arbiter_if
  #(parameter int NUM_REQ = sprite_pkg::NUM_REQ_DEF,
    parameter int ADDR_W  = sprite_pkg::ADDR_W_DEF,
    parameter int DATA_W  = sprite_pkg::DATA_W_DEF);

  logic                      enable;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [15:0]               stall_cnt;

  modport slave (
    input  enable, req_valid, req_addr, mem_data,
    output req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, stall_cnt
  );

  modport master (
    output enable, req_valid, req_addr, mem_data,
    input  req_ready, mem_rd, mem_addr, rsp_valid, rsp_data, stall_cnt
  );

endinterface

// File: rtl/sprite_rom_arbiter_rr_arbiter.sv
// Combinational round-robin select: first set bit of req at or above ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic             found;
  int               idx;
  logic [PTR_W-1:0] sel;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = PTR_W'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous-read sprite ROM between NUM_REQ requesters with
// round-robin grants and a tagged, fixed-latency (RD_LAT+2) response path.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = 1
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int PTR_W = idx_w(NUM_REQ);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] arb_req, gnt;
  logic               hs;

  logic               mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;

  // One-hot grant tag travels beside the read; stage k is valid k+1 cycles after grant
  logic [RD_LAT:0][NUM_REQ-1:0] tag_pipe_q, tag_pipe_d;

  // Reset gates the grant path so req_ready stays low while Reset_n is held
  assign arb_req = bus.req_valid & {NUM_REQ{bus.enable & Reset_n}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (arb_req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign hs = |gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_comb begin
    mem_rd_d   = hs;
    mem_addr_d = mem_addr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) mem_addr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    tag_pipe_d    = '0;
    tag_pipe_d[0] = gnt;
    for (int k = 1; k <= RD_LAT; k++) tag_pipe_d[k] = tag_pipe_q[k-1];
  end

  always_comb begin
    rsp_valid_d = tag_pipe_q[RD_LAT];
    rsp_data_d  = rsp_data_q;
    if (|tag_pipe_q[RD_LAT]) rsp_data_d = bus.mem_data;
  end

  // Counts any cycle where a valid requester is left waiting, enable low included
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|(bus.req_valid & ~gnt)) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      tag_pipe_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      tag_pipe_q  <= tag_pipe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=3) share the same
// stimulus; each has its own ROM model and expected-response schedule.
module tb_sprite_rom_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        en;
  logic [3:0]  rv;
  logic [47:0] ra;
  logic [23:0] r1, p0, p1, p2;

  always #5 Clk = ~Clk;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24)) if1 ();
  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24)) if3 ();

  assign if1.enable    = en;
  assign if1.req_valid = rv;
  assign if1.req_addr  = ra;
  assign if1.mem_data  = r1;
  assign if3.enable    = en;
  assign if3.req_valid = rv;
  assign if3.req_addr  = ra;
  assign if3.mem_data  = p2;

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24), .RD_LAT(1)) u_lat1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if1.slave));
  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(12), .DATA_W(24), .RD_LAT(3)) u_lat3 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(if3.slave));

  function automatic logic [23:0] rom(input logic [11:0] a);
    return {a ^ 12'h5A5, a};
  endfunction

  // ROM models: data appears RD_LAT cycles after the address is presented
  always @(posedge Clk) begin
    r1 <= rom(if1.mem_addr);
    p0 <= rom(if3.mem_addr);
    p1 <= p0;
    p2 <= p1;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  logic [3:0]  ev1 [256];
  logic [3:0]  ev3 [256];
  logic [23:0] ed1 [256];
  logic [23:0] ed3 [256];
  logic        em  [256];
  logic [11:0] ea  [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clr_sched();
    for (int i = 0; i < 256; i++) begin
      ev1[i] = '0; ev3[i] = '0; ed1[i] = '0; ed3[i] = '0; em[i] = 1'b0; ea[i] = '0;
    end
  endtask

  int ms;
  always @(negedge Clk) begin
    ms = cyc % 256;
    chk("mem_rd1", {31'd0, if1.mem_rd}, {31'd0, em[ms]});
    chk("mem_rd3", {31'd0, if3.mem_rd}, {31'd0, em[ms]});
    if (em[ms]) begin
      chk("mem_addr1", {20'd0, if1.mem_addr}, {20'd0, ea[ms]});
      chk("mem_addr3", {20'd0, if3.mem_addr}, {20'd0, ea[ms]});
    end
    chk("rsp_valid1", {28'd0, if1.rsp_valid}, {28'd0, ev1[ms]});
    chk("rsp_valid3", {28'd0, if3.rsp_valid}, {28'd0, ev3[ms]});
    if (ev1[ms] != 4'd0) chk("rsp_data1", {8'd0, if1.rsp_data}, {8'd0, ed1[ms]});
    if (ev3[ms] != 4'd0) chk("rsp_data3", {8'd0, if3.rsp_data}, {8'd0, ed3[ms]});
    ev1[ms] = '0; ev3[ms] = '0; em[ms] = 1'b0;
  end

  // Check grant and stall count this cycle, book the expected read and responses
  task automatic step(input logic [3:0] exp, input logic [15:0] est);
    logic [11:0] a;
    @(negedge Clk);
    chk("req_ready1", {28'd0, if1.req_ready}, {28'd0, exp});
    chk("req_ready3", {28'd0, if3.req_ready}, {28'd0, exp});
    chk("stall_cnt1", {16'd0, if1.stall_cnt}, {16'd0, est});
    chk("stall_cnt3", {16'd0, if3.stall_cnt}, {16'd0, est});
    for (int i = 0; i < 4; i++) begin
      if (exp[i]) begin
        a = ra[i*12 +: 12];
        em[(cyc+1)%256]  = 1'b1;
        ea[(cyc+1)%256]  = a;
        ev1[(cyc+3)%256] = exp;
        ed1[(cyc+3)%256] = rom(a);
        ev3[(cyc+5)%256] = exp;
        ed3[(cyc+5)%256] = rom(a);
      end
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    clr_sched();
    Reset_n = 1'b0;
    en      = 1'b1;
    rv      = 4'hF;
    ra      = {12'h040, 12'h030, 12'h020, 12'h010};

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready1", {28'd0, if1.req_ready}, 32'd0);
    chk("rst_ready3", {28'd0, if3.req_ready}, 32'd0);
    chk("rst_mem_rd", {31'd0, if1.mem_rd}, 32'd0);
    chk("rst_mem_addr", {20'd0, if1.mem_addr}, 32'd0);
    chk("rst_rsp_valid", {28'd0, if1.rsp_valid}, 32'd0);
    chk("rst_rsp_data", {8'd0, if1.rsp_data}, 32'd0);
    chk("rst_stall", {16'd0, if1.stall_cnt}, 32'd0);
    chk("rst_mem_rd3", {31'd0, if3.mem_rd}, 32'd0);
    chk("rst_rsp_data3", {8'd0, if3.rsp_data}, 32'd0);
    chk("rst_stall3", {16'd0, if3.stall_cnt}, 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // full contention: 0,1,2,3,0,... with three losers stalling each cycle
    step(4'b0001, 16'd0); step(4'b0010, 16'd1); step(4'b0100, 16'd2); step(4'b1000, 16'd3);
    step(4'b0001, 16'd4); step(4'b0010, 16'd5); step(4'b0100, 16'd6); step(4'b1000, 16'd7);
    rv = 4'h0;
    repeat (4) step(4'b0000, 16'd8);

    // single requester 2, back-to-back, no stalls
    for (int k = 0; k < 8; k++) begin
      rv = 4'b0100;
      ra[35:24] = 12'(256 + k);
      step(4'b0100, 16'd8);
    end
    rv = 4'h0;
    repeat (6) step(4'b0000, 16'd8);

    // enable drop after two grants (ptr is 3 here)
    ra = {12'h040, 12'h030, 12'h020, 12'h010};
    rv = 4'hF;
    step(4'b1000, 16'd8);
    step(4'b0001, 16'd9);
    en = 1'b0;
    step(4'b0000, 16'd10); step(4'b0000, 16'd11);
    step(4'b0000, 16'd12); step(4'b0000, 16'd13);
    rv = 4'h0;
    en = 1'b1;
    repeat (6) step(4'b0000, 16'd14);

    // reset one cycle after a handshake (ptr is 1 here)
    rv = 4'b0001;
    step(4'b0001, 16'd14);
    Reset_n = 1'b0;
    rv = 4'h0;
    clr_sched();
    step(4'b0000, 16'd0);
    step(4'b0000, 16'd0);
    Reset_n = 1'b1;
    repeat (6) step(4'b0000, 16'd0);
    rv = 4'hF;
    step(4'b0001, 16'd0);
    rv = 4'b1010;
    step(4'b0010, 16'd1);
    step(4'b1000, 16'd2);
    rv = 4'h0;
    repeat (6) step(4'b0000, 16'd3);

    // saturation: long blocked stretch must pin at FFFF
    en = 1'b0;
    rv = 4'b0001;
    repeat (70000) @(posedge Clk);
    #1;
    step(4'b0000, 16'hFFFF);
    step(4'b0000, 16'hFFFF);
    rv = 4'h0;
    en = 1'b1;
    step(4'b0000, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
